music_key_record_player: RTL and testbench

MUSIC_KEY_RECORD_PLAYER -- requirements
Module: music_key_record_player

---
 rtl/music_box_pkg.sv | 36 +++
 rtl/music_key_record_player_if.sv | 33 +++
 rtl/key_event_buffer.sv | 25 ++
 rtl/music_key_record_player.sv | 165 ++++++++++++++++
 tb/tb_music_key_record_player.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/music_box_pkg.sv
// Shared types and constants for the music box key recorder/player.
package music_box_pkg;

    localparam int KEY_W           = 6;
    localparam int DELTA_W_DEFAULT = 10;

    // Keys are active-low, so "nothing pressed" is all ones
    localparam logic [KEY_W-1:0] KEYS_IDLE = 6'h3F;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REC      = 2'd1,
        ST_PLAY     = 2'd2,
        ST_PLAY_END = 2'd3
    } fsm_state_e;

    typedef struct packed {
        logic [DELTA_W_DEFAULT-1:0] delta;
        logic [KEY_W-1:0]           keys;
    } key_event_t;

    function automatic fsm_state_e decode_state(
        input logic [4:0] code,
        input logic [4:0] rec_code,
        input logic [4:0] play_code
    );
        if (code == rec_code) begin
            return ST_REC;
        end
        if (code == play_code) begin
            return ST_PLAY;
        end
        return ST_IDLE;
    endfunction

endpackage

// File: rtl/music_key_record_player_if.sv
// Write/read bus between the record/play controller and the event buffer.
interface music_key_record_player_if #(
    parameter int DEPTH   = 64,
    parameter int DELTA_W = 10
);
    import music_box_pkg::*;

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int W  = DELTA_W + KEY_W;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        output rd_addr,
        input  rd_data
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  rd_addr,
        output rd_data
    );

endinterface

// File: rtl/key_event_buffer.sv
// DEPTH-entry event store: one synchronous write port, one combinational read port.
module key_event_buffer
    import music_box_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int DELTA_W = 10
)(
    input logic                      clk,
    music_key_record_player_if.slave bus
);

    localparam int W = DELTA_W + KEY_W;

    // Contents are deliberately left unreset; the event count gates every read.
    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            mem_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign bus.rd_data = mem_q[bus.rd_addr];

endmodule

// File: rtl/music_key_record_player.sv
// Records timestamped key changes while in the record state and replays them cycle-exactly.
module music_key_record_player
    import music_box_pkg::*;
#(
    parameter int         DEPTH        = 64,
    parameter int         DELTA_W      = 10,
    parameter logic [4:0] STATE_RECORD = 5'd3,
    parameter logic [4:0] STATE_PLAY   = 5'd4
)(
    input  logic        CLK_1Khz,
    input  logic        reset_n,
    input  logic [4:0]  currentState,
    input  logic [5:0]  input_MusicKey,
    output logic [5:0]  output_MusicKey,
    output logic [6:0]  eventCount,
    output logic        recordingFull,
    output logic        playbackDone,
    output logic [31:0] debugString
);

    localparam int                 AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [6:0]         DEPTH_C   = 7'(DEPTH);
    localparam logic [DELTA_W-1:0] DELTA_MAX = '1;

    fsm_state_e state_q, state_d, decoded, cur_mode;
    logic       entry;
    logic       play_last;
    logic       wr_en;

    logic [6:0]         cnt_q, cnt_d;
    logic [6:0]         rd_q, rd_d;
    logic [DELTA_W-1:0] delta_q, delta_d;
    logic [DELTA_W-1:0] timer_q, timer_d;
    logic [5:0]         key_q, key_d;
    logic [5:0]         out_q, out_d;
    logic               full_q, full_d;

    logic [DELTA_W-1:0] rd_delta;
    logic [5:0]         rd_keys;

    music_key_record_player_if #(.DEPTH(DEPTH), .DELTA_W(DELTA_W)) buf_if ();

    key_event_buffer #(
        .DEPTH   (DEPTH),
        .DELTA_W (DELTA_W)
    ) u_key_event_buffer (
        .clk (CLK_1Khz),
        .bus (buf_if)
    );

    assign buf_if.wr_en   = wr_en & reset_n;
    assign buf_if.wr_addr = cnt_q[AW-1:0];
    assign buf_if.wr_data = {delta_q, input_MusicKey};
    assign buf_if.rd_addr = rd_q[AW-1:0];
    assign {rd_delta, rd_keys} = buf_if.rd_data;

    // PLAY_END is still "playing" as far as the decoded request is concerned
    assign decoded   = decode_state(currentState, STATE_RECORD, STATE_PLAY);
    assign cur_mode  = (state_q == ST_PLAY_END) ? ST_PLAY : state_q;
    assign entry     = (decoded != cur_mode);
    assign play_last = (rd_q == cnt_q);

    always_ff @(posedge CLK_1Khz) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : next_state_comb
        state_d = state_q;
        if (entry) begin
            state_d = decoded;
        end else if ((state_q == ST_PLAY) && play_last) begin
            state_d = ST_PLAY_END;
        end
    end

    always_comb begin : output_comb
        cnt_d   = cnt_q;
        full_d  = full_q;
        delta_d = delta_q;
        key_d   = key_q;
        rd_d    = rd_q;
        timer_d = timer_q;
        out_d   = out_q;
        wr_en   = 1'b0;
        if (entry) begin
            out_d = KEYS_IDLE;
            case (decoded)
                ST_REC: begin
                    cnt_d   = '0;
                    full_d  = 1'b0;
                    delta_d = '0;
                    key_d   = KEYS_IDLE;
                end
                ST_PLAY: begin
                    rd_d    = '0;
                    timer_d = '0;
                end
                default: begin
                end
            endcase
        end else begin
            case (state_q)
                ST_REC: begin
                    if (cnt_q == DEPTH_C) begin
                        full_d = 1'b1;
                    end else if ((input_MusicKey != key_q) || (delta_q == DELTA_MAX)) begin
                        wr_en   = 1'b1;
                        key_d   = input_MusicKey;
                        delta_d = '0;
                        cnt_d   = cnt_q + 7'd1;
                        full_d  = (cnt_q + 7'd1 == DEPTH_C);
                    end else begin
                        delta_d = delta_q + 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (play_last) begin
                        out_d = KEYS_IDLE;
                    end else if (timer_q == rd_delta) begin
                        out_d   = rd_keys;
                        rd_d    = rd_q + 7'd1;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: begin
                    out_d = KEYS_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK_1Khz) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            full_q  <= 1'b0;
            delta_q <= '0;
            key_q   <= KEYS_IDLE;
            rd_q    <= '0;
            timer_q <= '0;
            out_q   <= KEYS_IDLE;
        end else begin
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            delta_q <= delta_d;
            key_q   <= key_d;
            rd_q    <= rd_d;
            timer_q <= timer_d;
            out_q   <= out_d;
        end
    end

    // Done is decided in the cycle that finds the buffer exhausted, so it is not registered
    assign playbackDone    = reset_n && (state_q == ST_PLAY) && !entry && play_last;
    assign output_MusicKey = out_q;
    assign eventCount      = cnt_q;
    assign recordingFull   = full_q;
    assign debugString     = {8'(rd_q), 8'(cnt_q), 4'(state_q), 12'(timer_q)};

endmodule

// File: tb/tb_music_key_record_player.sv
// Randomized scoreboard bench: playback is predicted as a one-cycle-delayed copy of the recorded input.
module tb_music_key_record_player;
    import music_box_pkg::*;

    localparam int         DEPTH   = 64;
    localparam int         DELTA_W = 10;
    localparam logic [4:0] ST_R    = 5'd3;
    localparam logic [4:0] ST_P    = 5'd4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  currentState;
    logic [5:0]  input_MusicKey;
    logic [5:0]  output_MusicKey;
    logic [6:0]  eventCount;
    logic        recordingFull;
    logic        playbackDone;
    logic [31:0] debugString;

    always #5 clk = ~clk;

    music_key_record_player #(
        .DEPTH        (DEPTH),
        .DELTA_W      (DELTA_W),
        .STATE_RECORD (ST_R),
        .STATE_PLAY   (ST_P)
    ) dut (
        .CLK_1Khz        (clk),
        .reset_n         (reset_n),
        .currentState    (currentState),
        .input_MusicKey  (input_MusicKey),
        .output_MusicKey (output_MusicKey),
        .eventCount      (eventCount),
        .recordingFull   (recordingFull),
        .playbackDone    (playbackDone),
        .debugString     (debugString)
    );

    typedef struct {
        int         cyc;
        logic [5:0] keys;
        logic       done;
    } exp_t;

    int         cyc    = 0;
    int         errors = 0;
    int         checks = 0;
    exp_t       exp_q[$];
    key_event_t model_ev[$];
    int         model_L;
    logic [5:0] rec_in [0:2600];
    bit         mon_en = 1'b0;
    logic [5:0] prev_out;

    always @(posedge clk) cyc <= cyc + 1;

    // Any visible output activity must match the next predicted event, in order and in time
    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en) begin
            if ((output_MusicKey !== prev_out) || (playbackDone !== 1'b0)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output cyc=%0d actual keys=%b done=%b required no activity",
                             cyc, output_MusicKey, playbackDone);
                end else begin
                    e = exp_q.pop_front();
                    if ((e.cyc != cyc) || (e.keys !== output_MusicKey) || (e.done !== playbackDone)) begin
                        errors++;
                        $display("FAIL playback_event actual cyc=%0d keys=%b done=%b required cyc=%0d keys=%b done=%b",
                                 cyc, output_MusicKey, playbackDone, e.cyc, e.keys, e.done);
                    end else begin
                        $display("event ok cyc=%0d keys=%b done=%b", cyc, output_MusicKey, playbackDone);
                    end
                end
            end
            prev_out = output_MusicKey;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end else begin
            $display("check ok %s value=%0d", name, act);
        end
    endtask

    // An event is stored whenever the keys differ from the last stored keys or 1024 cycles pass unchanged
    function automatic void model_record(input int n);
        key_event_t e;
        int         prev;
        logic [5:0] kq;
        prev = 0;
        kq   = KEYS_IDLE;
        model_ev.delete();
        for (int k = 1; k <= n; k++) begin
            if (model_ev.size() == DEPTH) break;
            if ((rec_in[k] != kq) || (k - prev - 1 == (1 << DELTA_W) - 1)) begin
                e.delta = 10'(k - prev - 1);
                e.keys  = rec_in[k];
                model_ev.push_back(e);
                kq   = rec_in[k];
                prev = k;
            end
        end
        model_L = 0;
        foreach (model_ev[i]) model_L += int'(model_ev[i].delta) + 1;
    endfunction

    task automatic record(input int n, input string tag);
        currentState   = ST_R;
        input_MusicKey = 6'($urandom);
        for (int k = 1; k <= n; k++) begin
            step();
            input_MusicKey = rec_in[k];
        end
        step();
        model_record(n);
        check({tag, "_count"}, int'(eventCount), model_ev.size());
        check({tag, "_full"}, int'(recordingFull), int'(model_ev.size() == DEPTH));
    endtask

    task automatic play(input int abort_c, input string tag);
        int         p;
        int         last;
        logic [5:0] prv;
        logic [5:0] o;
        logic       d;
        exp_t       e;
        p              = cyc;
        currentState   = ST_P;
        input_MusicKey = 6'($urandom);
        last = model_L + 3;
        if ((abort_c > 0) && (abort_c + 1 < last)) last = abort_c + 1;
        prv = KEYS_IDLE;
        for (int c = 1; c <= last; c++) begin
            if ((abort_c > 0) && (c > abort_c)) o = KEYS_IDLE;
            else if (c <= model_L + 1)          o = rec_in[c-1];
            else                                o = KEYS_IDLE;
            d = (c == model_L + 1) && ((abort_c == 0) || (c < abort_c));
            if ((o != prv) || d) begin
                e.cyc  = p + c;
                e.keys = o;
                e.done = d;
                exp_q.push_back(e);
            end
            prv = o;
        end
        for (int c = 1; c <= last + 2; c++) begin
            step();
            input_MusicKey = 6'($urandom);
            if (c == abort_c) currentState = 5'd0;
        end
        currentState = 5'd0;
        step();
        step();
        check({tag, "_pending_events"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int n;
        int ab;
        logic [5:0] v;
        rec_in[0]      = KEYS_IDLE;
        reset_n        = 1'b0;
        currentState   = 5'd0;
        input_MusicKey = KEYS_IDLE;
        repeat (3) step();
        check("reset_out", int'(output_MusicKey), 'h3F);
        check("reset_count", int'(eventCount), 0);
        check("reset_full", int'(recordingFull), 0);
        check("reset_done", int'(playbackDone), 0);
        check("reset_debug", int'(debugString), 0);
        reset_n  = 1'b1;
        prev_out = output_MusicKey;
        mon_en   = 1'b1;
        step();

        // Key 0 pressed at cycle 5, released at cycle 25
        for (int k = 1; k <= 30; k++) rec_in[k] = ((k >= 5) && (k < 25)) ? 6'h3E : 6'h3F;
        record(30, "press20");
        check("press20_events_const", int'(eventCount), 2);
        currentState = 5'd0;
        step();
        play(0, "press20");

        // Two saturation events, then key 2 at cycle 2500
        for (int k = 1; k <= 2500; k++) rec_in[k] = (k == 2500) ? 6'h3B : 6'h3F;
        record(2500, "saturate");
        check("saturate_events_const", int'(eventCount), 3);
        currentState = 5'd0;
        step();
        play(0, "saturate");

        // Toggle key 0 every cycle: buffer fills at 64
        for (int k = 1; k <= 70; k++) rec_in[k] = k[0] ? 6'h3E : 6'h3F;
        record(70, "toggle");
        check("toggle_count_const", int'(eventCount), 64);
        check("toggle_full_const", int'(recordingFull), 1);
        currentState = 5'd0;
        step();
        play(0, "toggle");

        // Empty buffer
        record(0, "empty");
        currentState = 5'd0;
        step();
        play(0, "empty");

        // Abort mid-playback while key 4 is held
        for (int k = 1; k <= 40; k++) rec_in[k] = ((k >= 3) && (k <= 30)) ? 6'h2F : 6'h3F;
        record(40, "abort");
        currentState = 5'd0;
        step();
        play(15, "abort");

        // One-cycle reset in the middle of recording
        currentState = ST_R;
        for (int k = 0; k < 10; k++) begin
            step();
            input_MusicKey = 6'($urandom);
        end
        reset_n = 1'b0;
        step();
        check("midrec_reset_count", int'(eventCount), 0);
        check("midrec_reset_full", int'(recordingFull), 0);
        check("midrec_reset_fsm_idle", int'(debugString[15:12]), 0);
        reset_n = 1'b1;
        model_record(0);
        play(0, "midrec_reset");

        // Randomized rounds, some with a direct record-to-play switch or an abort
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(20, 400);
            v = KEYS_IDLE;
            for (int k = 1; k <= n; k++) begin
                if ($urandom_range(0, 5) == 0) v = 6'($urandom);
                rec_in[k] = v;
            end
            record(n, $sformatf("rand%0d", r));
            if ($urandom_range(0, 1) == 1) begin
                currentState = 5'd0;
                step();
            end
            ab = 0;
            if (($urandom_range(0, 3) == 0) && (model_L > 0)) ab = $urandom_range(1, model_L + 1);
            play(ab, $sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
